// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential signed divider.
//   div_state_e  : controller state encoding (IDLE, ITER, FIX, DONE)
//   DIV_WIDTH    : default operand/result width
//   DIV_LATENCY  : start edge to RDY cycle, in clocks, at the default width
//   INT_MIN      : most negative operand at the default width
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;
    localparam logic [DIV_WIDTH-1:0] INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division step: trial subtract of the divisor magnitude from
// the shifted partial remainder, keeping the difference when it is not
// negative.
//   rem_shift  in  WIDTH+1  partial remainder shifted left with next dividend bit
//   divisor    in  WIDTH    divisor magnitude
//   rem_next   out WIDTH    partial remainder after this step
//   quo_bit    out 1        quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_shift,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quo_bit
);

    logic [WIDTH:0] divisor_inv;
    logic [WIDTH:0] diff;

    // Subtract in adder form: rem + ~B + carry-in of 1.
    assign divisor_inv = ~{1'b0, divisor};
    assign diff        = rem_shift + divisor_inv + {{WIDTH{1'b0}}, 1'b1};

    // The shifted remainder is below 2*|B|, so the WIDTH+1-bit difference
    // never wraps and its top bit is a true sign.
    assign quo_bit  = ~diff[WIDTH];

    // When the trial fails rem_shift < |B|, so its top bit is zero and the
    // low WIDTH bits hold the whole value.
    assign rem_next = quo_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle signed integer divider. Operand magnitudes are divided by
// shift-and-subtract, one quotient bit per clock, and signs are applied in
// a final fix-up cycle. Result and exception are registered and flagged by a
// one-cycle data_resultRDY pulse.
//
// Optional feature: define DIV_REMAINDER_EN to expose data_remainder
// (sign follows the dividend, zero on exception). Without it the remainder
// stays internal and timing/quotient are unchanged.
//
// Ports
//   clock           in   1      rising-edge clock
//   reset           in   1      synchronous active-high reset
//   ctrl_DIV        in   1      start pulse, operands sampled on the same edge
//   data_operandA   in   WIDTH  dividend, two's complement
//   data_operandB   in   WIDTH  divisor, two's complement
//   data_result     out  WIDTH  quotient, truncated toward zero
//   data_exception  out  1      divide-by-zero or overflow, valid with RDY
//   data_resultRDY  out  1      one-cycle pulse when outputs are valid
//   data_remainder  out  WIDTH  remainder (DIV_REMAINDER_EN only)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for ctrl_DIV; outputs hold last result
// ITER  | one shift-and-subtract step per cycle, WIDTH steps
// FIX   | apply signs to quotient and remainder
// DONE  | register outputs and pulse data_resultRDY on the next edge
//
// ctrl_DIV in any state restarts the operation; reset overrides ctrl_DIV.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Package constants describe the default width; other widths derive
    // the same quantities locally.
    localparam logic [WIDTH-1:0] MIN_NEG =
        (WIDTH == DIV_WIDTH) ? WIDTH'(INT_MIN) : {1'b1, {(WIDTH-1){1'b0}}};

    // Latency = start edge + WIDTH steps + FIX + DONE, so the last step is
    // counted at latency - 3.
    localparam int LATENCY   = (WIDTH == DIV_WIDTH) ? DIV_LATENCY : WIDTH + 2;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(LATENCY - 3);

    div_state_e       state_q;
    div_state_e       state_d;

    logic [WIDTH-1:0] dvd_q;      // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] dsr_q;      // divisor magnitude
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             exc_q;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             overflow;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_next;
    logic             quo_bit;

    assign sign_a   = data_operandA[WIDTH-1];
    assign sign_b   = data_operandB[WIDTH-1];
    // INT_MIN negates to itself, which is already the right unsigned magnitude.
    assign mag_a    = sign_a ? (~data_operandA + 1'b1) : data_operandA;
    assign mag_b    = sign_b ? (~data_operandB + 1'b1) : data_operandB;
    assign div_zero = (data_operandB == '0);
    assign overflow = (data_operandA == MIN_NEG) && (data_operandB == '1);

    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_shift (rem_shift),
        .divisor   (dsr_q),
        .rem_next  (rem_next),
        .quo_bit   (quo_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_DIV) begin
            state_d = div_zero ? DONE : ITER;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ITER:    if (cnt_q == ITER_LAST) state_d = FIX;
                FIX:     state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dvd_q          <= '0;
            dsr_q          <= '0;
            quo_q          <= '0;
            rem_q          <= '0;
            cnt_q          <= '0;
            sign_a_q       <= 1'b0;
            sign_b_q       <= 1'b0;
            exc_q          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
            data_remainder <= '0;
`endif
        end else begin
            // RDY and exception are single-cycle; DONE reasserts them.
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;

            if (ctrl_DIV) begin
                dvd_q    <= mag_a;
                dsr_q    <= mag_b;
                quo_q    <= '0;
                rem_q    <= '0;
                cnt_q    <= '0;
                sign_a_q <= sign_a;
                sign_b_q <= sign_b;
                // Overflow is recognised from the raw operands; its wrapped
                // quotient still comes out of the normal datapath.
                exc_q    <= div_zero | overflow;
            end else begin
                case (state_q)
                    ITER: begin
                        dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                        rem_q <= rem_next;
                        quo_q <= {quo_q[WIDTH-2:0], quo_bit};
                        cnt_q <= cnt_q + 1'b1;
                    end
                    FIX: begin
                        if (sign_a_q ^ sign_b_q) begin
                            quo_q <= ~quo_q + 1'b1;
                        end
                        if (exc_q) begin
                            rem_q <= '0;
                        end else if (sign_a_q) begin
                            rem_q <= ~rem_q + 1'b1;
                        end
                    end
                    DONE: begin
                        data_result    <= quo_q;
                        data_exception <= exc_q;
                        data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
                        data_remainder <= rem_q;
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule : seq_divider
